// File: rtl/arm_banked_regfile.sv
// Banked ARM register file (31 GPRs, PC, CPSR, 5 SPSRs) with a 2-cycle exception-entry sequencer; REGBANK_RD_BYPASS_EN adds write-to-read forwarding.
// Reads are combinational, writes land on the next edge; no backpressure, but all writes are dropped while busy.
module arm_banked_regfile #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       NUM_RD     = 3,
  parameter int unsigned       PC_STEP    = 4,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [4:0]        RESET_MODE = 5'b10011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_wr_en,
  input  logic [DATA_W-1:0]        pc_wr_data,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc,
  input  logic                     cpsr_wr_en,
  input  logic [DATA_W-1:0]        cpsr_wr_data,
  input  logic [DATA_W-1:0]        cpsr_wr_mask,
  output logic [DATA_W-1:0]        cpsr,
  input  logic                     spsr_wr_en,
  output logic [DATA_W-1:0]        spsr,
  input  logic                     exc_req,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_vector,
  output logic                     exc_ack,
  output logic                     busy
);
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [DATA_W-1:0] LOW32      = DATA_W'(32'hFFFF_FFFF);
  localparam logic [DATA_W-1:0] RESET_CPSR = DATA_W'({24'h0, 3'b110, RESET_MODE});

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_VECTOR} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] usr_q  [15];
  logic [DATA_W-1:0] usr_d  [15];
  logic [DATA_W-1:0] fiq_q  [7];
  logic [DATA_W-1:0] fiq_d  [7];
  logic [DATA_W-1:0] bnk_q  [8];
  logic [DATA_W-1:0] bnk_d  [8];
  logic [DATA_W-1:0] spsr_q [5];
  logic [DATA_W-1:0] spsr_d [5];
  logic [DATA_W-1:0] pc_q, pc_d, cpsr_q, cpsr_d, exc_vec_q, exc_vec_d;
  logic [4:0]        exc_mode_q, exc_mode_d;

  // Bank code: 0 user (USR/SYS/invalid), 1 FIQ, 2..5 IRQ/SVC/ABT/UND.
  function automatic logic [2:0] bank_of(input logic [4:0] m);
    case (m)
      M_FIQ:   bank_of = 3'd1;
      M_IRQ:   bank_of = 3'd2;
      M_SVC:   bank_of = 3'd3;
      M_ABT:   bank_of = 3'd4;
      M_UND:   bank_of = 3'd5;
      default: bank_of = 3'd0;
    endcase
  endfunction

  logic [2:0]        cur_bank, exc_bank, w_bank;
  logic              w_en, gpr_wr_acc;
  logic [3:0]        w_addr, ra;
  logic [DATA_W-1:0] w_val, rv;

  assign cur_bank   = bank_of(cpsr_q[4:0]);
  assign exc_bank   = bank_of(exc_mode_q);
  assign gpr_wr_acc = (state_q == S_IDLE) && wr_en && (wr_addr != 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      cpsr_q     <= RESET_CPSR;
      exc_mode_q <= '0;
      exc_vec_q  <= '0;
      for (int i = 0; i < 15; i++) usr_q[i]  <= '0;
      for (int i = 0; i < 7; i++)  fiq_q[i]  <= '0;
      for (int i = 0; i < 8; i++)  bnk_q[i]  <= '0;
      for (int i = 0; i < 5; i++)  spsr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cpsr_q     <= cpsr_d;
      exc_mode_q <= exc_mode_d;
      exc_vec_q  <= exc_vec_d;
      usr_q      <= usr_d;
      fiq_q      <= fiq_d;
      bnk_q      <= bnk_d;
      spsr_q     <= spsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (exc_req && bank_of(exc_mode) != 3'd0) state_d = S_SAVE;
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    exc_ack = (state_q == S_VECTOR);
  end

  always_comb begin
    usr_d      = usr_q;
    fiq_d      = fiq_q;
    bnk_d      = bnk_q;
    spsr_d     = spsr_q;
    pc_d       = pc_q;
    cpsr_d     = cpsr_q;
    exc_mode_d = exc_mode_q;
    exc_vec_d  = exc_vec_q;
    w_en       = 1'b0;
    w_bank     = cur_bank;
    w_addr     = wr_addr;
    w_val      = wr_data;
    case (state_q)
      S_IDLE: begin
        w_en = gpr_wr_acc;
        if (spsr_wr_en && cur_bank != 3'd0) spsr_d[cur_bank - 3'd1] = wr_data & LOW32;
        if (cpsr_wr_en)
          cpsr_d = ((cpsr_q & ~cpsr_wr_mask) | (cpsr_wr_data & cpsr_wr_mask)) & LOW32;
        if (pc_wr_en)                         pc_d = pc_wr_data;
        else if (wr_en && wr_addr == 4'd15)   pc_d = wr_data;
        else if (pc_inc)                      pc_d = pc_q + DATA_W'(PC_STEP);
        if (exc_req && bank_of(exc_mode) != 3'd0) begin
          exc_mode_d = exc_mode;
          exc_vec_d  = exc_vector;
        end
      end
      S_SAVE: begin
        // LR of the target mode takes the PC through the shared write path below.
        w_en   = 1'b1;
        w_bank = exc_bank;
        w_addr = 4'd14;
        w_val  = pc_q;
        spsr_d[exc_bank - 3'd1] = cpsr_q;
        cpsr_d[4:0] = exc_mode_q;
        cpsr_d[7]   = 1'b1;
        cpsr_d[5]   = 1'b0;
        if (exc_bank == 3'd1) cpsr_d[6] = 1'b1;
      end
      S_VECTOR: pc_d = exc_vec_q;
      default: ;
    endcase
    if (w_en) begin
      if (w_addr >= 4'd8 && w_bank == 3'd1)       fiq_d[3'(w_addr - 4'd8)] = w_val;
      else if (w_addr >= 4'd13 && w_bank >= 3'd2) bnk_d[{2'(w_bank - 3'd2), ~w_addr[0]}] = w_val;
      else                                        usr_d[w_addr] = w_val;
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[4*k +: 4];
      if (ra == 4'd15)                             rv = pc_q;
      else if (ra >= 4'd8 && cur_bank == 3'd1)     rv = fiq_q[3'(ra - 4'd8)];
      else if (ra >= 4'd13 && cur_bank >= 3'd2)    rv = bnk_q[{2'(cur_bank - 3'd2), ~ra[0]}];
      else                                         rv = usr_q[ra];
`ifdef REGBANK_RD_BYPASS_EN
      if (ra == 4'd15)                             rv = pc_d;
      else if (gpr_wr_acc && ra == wr_addr)        rv = wr_data;
`endif
      rd_data[DATA_W*k +: DATA_W] = rv;
    end
  end

  assign pc   = pc_q;
  assign cpsr = cpsr_q;
  assign spsr = (cur_bank == 3'd0) ? '0 : spsr_q[cur_bank - 3'd1];

endmodule

// File: doc/arm_banked_regfile.md
Name: arm_banked_regfile

Overview:
- Parametrised successor register bank for the ARM core: 16 logical registers mapped onto 31 physical GPRs by current CPSR mode, plus CPSR and 5 SPSRs.
- Three configurable-count read ports, one write port, dedicated PC port with auto-increment, and a masked CPSR write.
- Contains a 2-cycle exception-entry sequencer (save CPSR to SPSR, LR := PC, mode switch, PC := vector).
- Sits between decode/execute and the fetch unit; single clock, all state updated on posedge clk.

Parameters:
DATA_W, 32, register width (>= 32; CPSR/mode fields use low 32 bits, upper bits zero).
NUM_RD, 3, number of read ports (1..4).
PC_STEP, 4, PC increment applied by pc_inc.
RESET_PC, 0, PC value after reset.
RESET_MODE, 5'b10011, CPSR mode field after reset (SVC).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_addr  in  4*NUM_RD  logical register index per read port, port k at [4k+3:4k].
rd_data  out  DATA_W*NUM_RD  read data per port, combinational from current state.
wr_en  in  1  GPR write enable.
wr_addr  in  4  logical register to write.
wr_data  in  DATA_W  GPR write data.
pc_wr_en  in  1  direct PC write (branch).
pc_wr_data  in  DATA_W  new PC.
pc_inc  in  1  PC += PC_STEP.
pc  out  DATA_W  current PC (R15).
cpsr_wr_en  in  1  masked CPSR write.
cpsr_wr_data  in  DATA_W  CPSR data.
cpsr_wr_mask  in  DATA_W  bit mask; 1 = take new bit.
cpsr  out  DATA_W  current CPSR.
spsr_wr_en  in  1  write SPSR of current mode.
spsr  out  DATA_W  SPSR of current mode.
exc_req  in  1  exception entry request (level, held until exc_ack).
exc_mode  in  5  target mode.
exc_vector  in  DATA_W  handler address.
exc_ack  out  1  one-cycle pulse when entry completes.
busy  out  1  high while sequencer not IDLE.

Behaviour:
- Reset (async, rst_n=0): all GPRs and SPSRs 0; PC=RESET_PC; CPSR = I=1, F=1, T=0, mode=RESET_MODE (0x000000D3 for default); FSM IDLE; exc_ack=0, busy=0.
- Banking: R0-R7 shared; R8-R12 banked for FIQ only; R13/R14 banked for FIQ, IRQ, SVC, ABT, UND; USR and SYS share the user bank. Invalid mode encodings use the user bank. R15 is the PC in all modes.
- SPSR: one each for FIQ/IRQ/SVC/ABT/UND. In USR/SYS/invalid modes, spsr reads 0 and spsr_wr_en is ignored.
- Reads: combinational, no bypass — a write in cycle N is visible from cycle N+1. rd_addr=15 returns pc.
- CPSR write: cpsr <= (cpsr & ~mask) | (data & mask). A mode change alters banking from the next cycle.
- PC priority in one cycle: pc_wr_en > (wr_en && wr_addr==15) > pc_inc. The losers are dropped.
- spsr_wr_en writes wr_data. cpsr_wr_en plus spsr_wr_en in the same cycle: the SPSR is selected by the pre-update mode.
- FSM:
  - IDLE: exc_req with valid privileged exc_mode (FIQ/IRQ/SVC/ABT/UND) -> SAVE. A USR/SYS/invalid exc_mode is ignored: no ack, stays IDLE.
  - SAVE, 1 cycle: SPSR[exc_mode] := CPSR; LR[exc_mode] := PC; CPSR.mode := exc_mode, I := 1, T := 0, F := 1 only if exc_mode is FIQ -> VECTOR.
  - VECTOR, 1 cycle: PC := exc_vector; exc_ack = 1 -> IDLE.
  - busy = 1 in SAVE/VECTOR. All wr_en, pc_*, cpsr_wr_en and spsr_wr_en writes are ignored while busy. exc_mode and exc_vector are sampled in IDLE and held internally.
- exc_req still high in the cycle after ack: treated as a new request.
- Reset mid-sequence: aborts immediately to reset state; no partial commit beyond edges already taken.

Optional Feature:
- REGBANK_RD_BYPASS_EN defined: a read port whose rd_addr matches a same-cycle accepted GPR write to the same physical register returns wr_data. R15 reads return the winning PC-next value.
- Undefined: no bypass, as in Behaviour.

Test Plan:
- Reset -> pc=0, cpsr=0x000000D3, all rd_data=0, busy=0.
- In SVC, write R13=0x1111; CPSR mask 0x1F data 0x12 (IRQ); write R13=0x2222; back to SVC -> rd R13=0x1111. In IRQ -> 0x2222. R8 is unchanged across the switch.
- FIQ banking: in USR write R8=0xA; switch to FIQ, write R8=0xB -> R8=0xB in FIQ, 0xA in USR/SYS.
- pc=0x100 with pc_inc, pc_wr_en(0x400) and wr_en R15(0x200) all in one cycle -> pc=0x400. Next cycle pc_inc only -> pc=0x404.
- From USR with pc=0x80 and cpsr=0x10, exc_req mode=IRQ, vector=0x18 -> busy for 2 cycles, ack in the 2nd; then spsr=0x10, R14=0x80, cpsr mode=0x12 with I=1, pc=0x18. A wr_en issued during busy is dropped.
- exc_req with mode=USR -> no ack, no state change. rst_n asserted in SAVE -> reset values, busy=0.
